data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port data_memory.
//  Port 0 = core load/store path; port 1 = secondary master (debug/loader).
//  Accepts one request per handshake, drives the memory's write_en/address/
//  write_data for exactly one cycle, returns a registered response to the
//  granted requester. Memory read is combinational; writes commit on posedge clk.
// PARAMETERS
//  ADDRESS_WIDTH  6   word address width; must match data_memory
//  DATA_WIDTH     32  data word width; must match data_memory
// PORTS
//  clk             in   1    clock; all state updates on posedge
//  rst             in   1    synchronous, active-high reset
//  req0_valid      in   1    port 0 request present
//  req0_ready      out  1    port 0 request accepted this cycle
//  req0_write      in   1    1 = store, 0 = load
//  req0_address    in   AW   word address
//  req0_wdata      in   DW   store data
//  rsp0_valid      out  1    one-cycle response pulse for port 0
//  rsp0_rdata      out  DW   load data; 0 for stores
//  req1_* / rsp1_* same set as port 0, for port 1
//  mem_write_en    out  1    to data_memory write_en
//  mem_address     out  AW   to data_memory address
//  mem_write_data  out  DW   to data_memory write_data
//  mem_read_data   in   DW   from data_memory read_data
// BEHAVIOUR
//  - FSM: IDLE, ACCESS. Reset -> IDLE.
//  - IDLE: if any reqN_valid, arbiter picks winner W; reqW_ready=1
//    (combinational, same cycle); latch write/address/wdata/W; -> ACCESS.
//    Loser's ready=0; it holds valid+payload stable until accepted.
//  - ACCESS (one cycle): mem_address/mem_write_data from latched regs;
//    mem_write_en = latched write & !rst. Load: capture mem_read_data into
//    rspW_rdata. Store: rspW_rdata <= 0. -> IDLE unconditionally.
//  - rspW_valid is registered: high the cycle after ACCESS, for one cycle.
//    The FSM is back in IDLE that cycle and may accept the next request.
//  - Timing: handshake cycle N, memory access N+1, rsp_valid N+2.
//    Peak throughput: one request per 2 cycles.
//  - Stores and loads never overlap. Load after store to same address sees
//    the new data.
//  - No readys are asserted in ACCESS. reqN_ready=0 while rst=1.
//  - mem_write_en is 0 in IDLE. mem_address/mem_write_data hold their last
//    latched values; reset value 0.
//  - Reset values: state=IDLE, rsp0/1_valid=0, rsp0/1_rdata=0, latched
//    regs=0, last_grant=1 (port 0 wins the first contention).
//  - Reset asserted during ACCESS: the write is suppressed (gated by !rst),
//    no response is issued, FSM -> IDLE.
//  - reqN_valid toggling in ACCESS has no effect. Arbitration happens only
//    in IDLE.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin. On contention in IDLE, grant the
//    port != last_grant. last_grant updates on every accepted request.
//  DMEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins contention.
//    last_grant is unused.
//  Uncontended requests are granted immediately in both modes.
// TESTING
//  1. Port0 store addr 5 data 0xDEADBEEF, then port0 load addr 5
//     -> mem_write_en high 1 cycle; rsp0_valid at N+2; rsp0_rdata=0xDEADBEEF.
//  2. Both ports valid every cycle, 4 requests each.
//     RR_EN: grants alternate 0,1,0,1...
//     Fixed priority: port 0 gets all 4 first; port1 ready stays 0 until
//     req0_valid drops.
//  3. Port1 load addr 63 (wrap boundary) on freshly reset memory
//     -> rsp1_rdata=0; rsp0_valid stays 0 throughout.
//  4. Port0 store addr 10 data 0x1234, rst=1 in the ACCESS cycle; then
//     load addr 10 -> rdata=0, no rsp0_valid for the aborted store.
//  5. Back-to-back: port0 load accepted in the cycle its predecessor's
//     rsp0_valid=1 -> both responses correct; one handshake per 2 cycles.
//  6. Store to port1 addr 3 then port0 load addr 3 issued next IDLE
//     -> port0 reads port1's store data.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data_memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_memory_arbiter #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic                     req0_write,
   input  logic [ADDRESS_WIDTH-1:0] req0_address,
   input  logic [DATA_WIDTH-1:0]    req0_wdata,
   output logic                     rsp0_valid,
   output logic [DATA_WIDTH-1:0]    rsp0_rdata,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic                     req1_write,
   input  logic [ADDRESS_WIDTH-1:0] req1_address,
   input  logic [DATA_WIDTH-1:0]    req1_wdata,
   output logic                     rsp1_valid,
   output logic [DATA_WIDTH-1:0]    rsp1_rdata,
   output logic                     mem_write_en,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   input  logic [DATA_WIDTH-1:0]    mem_read_data
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                   state_reg;
   logic                     write_reg;
   logic [ADDRESS_WIDTH-1:0] address_reg;
   logic [DATA_WIDTH-1:0]    wdata_reg;
   logic                     winner_reg;
`ifdef DMEM_ARB_RR_EN
   logic                     last_grant_reg;
`endif

   logic [1:0]               req_valid;
   logic [1:0]               grant;
   logic                     sel_write;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0]    sel_wdata;
   logic                     rsp_valid_reg [2];
   logic [DATA_WIDTH-1:0]    rsp_rdata_reg [2];

   assign req_valid = {req1_valid, req0_valid};

   // Grants are combinational so the requester sees ready in the same cycle.
   always_comb begin
      grant = 2'b00;
      if (state_reg == IDLE && !rst) begin
`ifdef DMEM_ARB_RR_EN
         if (&req_valid)
            grant = last_grant_reg ? 2'b01 : 2'b10;
         else
            grant = req_valid;
`else
         if (req_valid[0])
            grant = 2'b01;
         else if (req_valid[1])
            grant = 2'b10;
`endif
      end
   end

   assign req0_ready  = grant[0];
   assign req1_ready  = grant[1];
   assign sel_write   = grant[1] ? req1_write   : req0_write;
   assign sel_address = grant[1] ? req1_address : req0_address;
   assign sel_wdata   = grant[1] ? req1_wdata   : req0_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         write_reg   <= 1'b0;
         address_reg <= '0;
         wdata_reg   <= '0;
         winner_reg  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_grant_reg <= 1'b1;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (|grant) begin
                  write_reg   <= sel_write;
                  address_reg <= sel_address;
                  wdata_reg   <= sel_wdata;
                  winner_reg  <= grant[1];
`ifdef DMEM_ARB_RR_EN
                  last_grant_reg <= grant[1];
`endif
                  state_reg   <= ACCESS;
               end
            end
            ACCESS:  state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Reset in the access cycle must block the write before it reaches memory.
   assign mem_write_en   = (state_reg == ACCESS) && write_reg && !rst;
   assign mem_address    = address_reg;
   assign mem_write_data = wdata_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         always_ff @(posedge clk) begin
            if (rst) begin
               rsp_valid_reg[gi] <= 1'b0;
               rsp_rdata_reg[gi] <= '0;
            end else begin
               rsp_valid_reg[gi] <= (state_reg == ACCESS) && (winner_reg == 1'(gi));
               if (state_reg == ACCESS && winner_reg == 1'(gi))
                  rsp_rdata_reg[gi] <= write_reg ? '0 : mem_read_data;
            end
         end
      end
   endgenerate

   assign rsp0_valid = rsp_valid_reg[0];
   assign rsp0_rdata = rsp_rdata_reg[0];
   assign rsp1_valid = rsp_valid_reg[1];
   assign rsp1_rdata = rsp_rdata_reg[1];

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural data_memory model.
// Contention expectations follow DMEM_ARB_RR_EN.
module tb_data_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_write;
   logic [5:0]  req0_address;
   logic [31:0] req0_wdata;
   logic        rsp0_valid;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_write;
   logic [5:0]  req1_address;
   logic [31:0] req1_wdata;
   logic        rsp1_valid;
   logic [31:0] rsp1_rdata;
   logic        mem_write_en;
   logic [5:0]  mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:63];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   data_memory_arbiter #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_address(req0_address), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_address(req1_address), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   // Single-port memory: combinational read, write on posedge.
   assign mem_read_data = mem[mem_address];
   always @(posedge clk) if (mem_write_en) mem[mem_address] <= mem_write_data;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue one request at a negedge; ends at the negedge of the response cycle.
   task automatic do_req(input int port, input logic wr, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input string tag, output int waited);
      logic rdy;
      if (port == 0) begin
         req0_valid = 1'b1; req0_write = wr; req0_address = addr; req0_wdata = wd;
      end else begin
         req1_valid = 1'b1; req1_write = wr; req1_address = addr; req1_wdata = wd;
      end
      waited = 0;
      #1;
      rdy = (port == 0) ? req0_ready : req1_ready;
      while (!rdy && waited < 8) begin
         @(negedge clk); #1;
         waited++;
         rdy = (port == 0) ? req0_ready : req1_ready;
      end
      check_value({tag, "_ready"}, {31'd0, rdy}, 32'd1);
      @(negedge clk);
      check_value({tag, "_access_readys"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      check_value({tag, "_wen"}, {31'd0, mem_write_en}, {31'd0, wr});
      check_value({tag, "_addr"}, {26'd0, mem_address}, {26'd0, addr});
      if (wr) check_value({tag, "_wdata"}, mem_write_data, wd);
      check_value({tag, "_early_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
      check_value({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, (port == 0) ? 32'd1 : 32'd2);
      check_value({tag, "_rdata"}, (port == 0) ? rsp0_rdata : rsp1_rdata, exp_rd);
      $display("txn %s port=%0d write=%0d addr=%0d wdata=0x%0h rdata=0x%0h waited=%0d",
               tag, port, wr, addr, wd, (port == 0) ? rsp0_rdata : rsp1_rdata, waited);
   endtask

   int exp_seq [8];
   int w;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
`ifdef DMEM_ARB_RR_EN
      exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      rst = 1'b1;
      req0_valid = 1'b1; req0_write = 1'b1; req0_address = 6'd1; req0_wdata = 32'h1;
      req1_valid = 1'b1; req1_write = 1'b1; req1_address = 6'd2; req1_wdata = 32'h2;
      @(negedge clk);
      @(negedge clk);
      check_value("rst_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      check_value("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check_value("rst_rsp0_rdata", rsp0_rdata, 32'd0);
      check_value("rst_rsp1_rdata", rsp1_rdata, 32'd0);
      check_value("rst_wen", {31'd0, mem_write_en}, 32'd0);
      check_value("rst_mem_addr", {26'd0, mem_address}, 32'd0);
      check_value("rst_mem_wdata", mem_write_data, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Load at the top address of an untouched memory.
      do_req(1, 1'b0, 6'd63, 32'd0, 32'd0, "p1_load63", w);

      // Store then load through port 0.
      do_req(0, 1'b1, 6'd5, 32'hDEADBEEF, 32'd0, "p0_store5", w);
      @(negedge clk);
      check_value("idle_wen", {31'd0, mem_write_en}, 32'd0);
      check_value("idle_addr_hold", {26'd0, mem_address}, 32'd5);
      do_req(0, 1'b0, 6'd5, 32'd0, 32'hDEADBEEF, "p0_load5", w);

      // Back-to-back: next request accepted in the response cycle.
      do_req(0, 1'b1, 6'd7, 32'hCAFE0007, 32'd0, "b2b_store7", w);
      do_req(0, 1'b0, 6'd7, 32'd0, 32'hCAFE0007, "b2b_load7", w);
      check_value("b2b_wait1", w, 32'd0);
      do_req(0, 1'b0, 6'd5, 32'd0, 32'hDEADBEEF, "b2b_load5", w);
      check_value("b2b_wait2", w, 32'd0);

      // Port 1 store observed by a port 0 load.
      do_req(1, 1'b1, 6'd3, 32'hA5A50003, 32'd0, "p1_store3", w);
      do_req(0, 1'b0, 6'd3, 32'd0, 32'hA5A50003, "p0_load3", w);

      // Reset during the access cycle aborts the store.
      req0_valid = 1'b1; req0_write = 1'b1; req0_address = 6'd10; req0_wdata = 32'h1234;
      #1;
      check_value("abort_ready", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_write = 1'b0; req1_address = 6'd0;
      rst = 1'b1;
      #1;
      check_value("abort_wen", {31'd0, mem_write_en}, 32'd0);
      check_value("abort_ready_in_rst", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      req1_valid = 1'b0;
      rst = 1'b0;
      check_value("abort_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      $display("txn abort_store10 port=0 write=1 addr=10 aborted by reset");
      do_req(0, 1'b0, 6'd10, 32'd0, 32'd0, "p0_load10", w);

      // Sustained contention from a fresh reset.
      do_reset();
      req0_valid = 1'b1; req0_write = 1'b0; req0_address = 6'd5;
      req1_valid = 1'b1; req1_write = 1'b0; req1_address = 6'd3;
      begin
         int cnt0, cnt1;
         cnt0 = 0; cnt1 = 0;
         for (int k = 0; k < 8; k++) begin
            int g, tries;
            g = -1; tries = 0;
            #1;
            while (!(req0_ready || req1_ready) && tries < 4) begin
               @(negedge clk); #1;
               tries++;
            end
            if (req0_ready && req1_ready) g = 2;
            else if (req0_ready) g = 0;
            else if (req1_ready) g = 1;
            check_value($sformatf("contend_grant%0d", k), g, exp_seq[k]);
            if (g == 0) cnt0++;
            if (g == 1) cnt1++;
            @(negedge clk);
            if (cnt0 == 4) req0_valid = 1'b0;
            if (cnt1 == 4) req1_valid = 1'b0;
            @(negedge clk);
            check_value($sformatf("contend_rsp%0d", k), {30'd0, rsp1_valid, rsp0_valid},
                        (g == 1) ? 32'd2 : 32'd1);
            check_value($sformatf("contend_rdata%0d", k), (g == 1) ? rsp1_rdata : rsp0_rdata,
                        (g == 1) ? 32'hA5A50003 : 32'hDEADBEEF);
            $display("txn contend%0d grant=%0d", k, g);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
